// File: rtl/reg_bank_arbiter.sv
// Round-robin arbiter in front of one shared W-bit register.
// Each accepted write is followed by one ACK cycle, so there is at most one write every two cycles.
module reg_bank_arbiter #(
   parameter  int N  = 4,
   parameter  int W  = 8,
   localparam int OW = (N > 2) ? $clog2(N) : 1
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [N-1:0]   req,
   input  logic [N*W-1:0] wdata,
   input  logic           clr,
   output logic [N-1:0]   gnt,
   output logic [W-1:0]   q,
   output logic [OW-1:0]  owner,
   output logic           valid,
   output logic [7:0]     wr_count
);

   typedef enum logic {
      IDLE = 1'b0,
      ACK  = 1'b1
   } state_t;

   state_t          state, state_nx;
   logic [OW-1:0]   ptr, ptr_nx;
   logic [N-1:0]    gnt_nx;
   logic [W-1:0]    q_nx;
   logic [OW-1:0]   owner_nx;
   logic            valid_nx;
   logic [7:0]      cnt_nx;

   logic            found;
   logic [OW-1:0]   win;
   int              scan_idx;

   // First asserted request at or after ptr, wrapping modulo N.
   always_comb begin
      found    = 1'b0;
      win      = '0;
      scan_idx = 0;
      for (int k = 0; k < N; k++) begin
         scan_idx = int'(ptr) + k;
         if (scan_idx >= N) scan_idx = scan_idx - N;
         if (!found && req[scan_idx]) begin
            found = 1'b1;
            win   = OW'(scan_idx);
         end
      end
   end

   always_comb begin
      state_nx = state;
      ptr_nx   = ptr;
      gnt_nx   = '0;
      q_nx     = q;
      owner_nx = owner;
      valid_nx = valid;
      cnt_nx   = wr_count;
      case (state)
         IDLE: begin
            if (clr) begin
               q_nx     = '0;
               valid_nx = 1'b0;
            end else if (found) begin
               gnt_nx[win] = 1'b1;
               q_nx        = wdata[int'(win)*W +: W];
               owner_nx    = win;
               valid_nx    = 1'b1;
               cnt_nx      = wr_count + 8'd1;
               ptr_nx      = (win == OW'(N-1)) ? '0 : win + 1'b1;
               state_nx    = ACK;
            end
         end
         // Requests and clr are deliberately not looked at here.
         ACK: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         ptr      <= '0;
         gnt      <= '0;
         q        <= '0;
         owner    <= '0;
         valid    <= 1'b0;
         wr_count <= 8'd0;
      end else begin
         state    <= state_nx;
         ptr      <= ptr_nx;
         gnt      <= gnt_nx;
         q        <= q_nx;
         owner    <= owner_nx;
         valid    <= valid_nx;
         wr_count <= cnt_nx;
      end
   end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Scoreboard bench for reg_bank_arbiter: stimulus queues expected grants and state snapshots,
// a monitor compares them on the falling edge.
module tb_reg_bank_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req;
   logic [31:0] wdata;
   logic        clr;
   logic [3:0]  gnt;
   logic [7:0]  q;
   logic [1:0]  owner;
   logic        valid;
   logic [7:0]  wr_count;

   typedef struct {
      logic [3:0] gnt;
      logic [7:0] q;
      logic [1:0] owner;
      logic       valid;
      logic [7:0] cnt;
   } exp_t;

   exp_t grant_q[$];
   exp_t snap_q[$];
   logic done = 1'b0;
   int   checks = 0;
   int   passed = 0;

   reg_bank_arbiter #(.N(4), .W(8)) dut (
      .clk(clk), .reset(reset), .req(req), .wdata(wdata), .clr(clr),
      .gnt(gnt), .q(q), .owner(owner), .valid(valid), .wr_count(wr_count)
   );

   always #5 clk = ~clk;

   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic exp_t mk(input logic [3:0] g, input logic [7:0] d, input logic [1:0] o,
                               input logic v, input logic [7:0] c);
      exp_t e;
      e.gnt = g; e.q = d; e.owner = o; e.valid = v; e.cnt = c;
      return e;
   endfunction

   task automatic push_grant(input logic [3:0] g, input logic [7:0] d, input logic [1:0] o,
                             input logic [7:0] c);
      grant_q.push_back(mk(g, d, o, 1'b1, c));
   endtask

   task automatic push_snap(input logic [3:0] g, input logic [7:0] d, input logic [1:0] o,
                            input logic v, input logic [7:0] c);
      snap_q.push_back(mk(g, d, o, v, c));
   endtask

   // Stimulus
   initial begin
      reset = 1'b1; req = '0; wdata = '0; clr = 1'b0;
      step();
      reset = 1'b0;
      push_snap(4'b0000, 8'h00, 2'd0, 1'b0, 8'd0);
      step();
      push_snap(4'b0000, 8'h00, 2'd0, 1'b0, 8'd0);

      // single write from requester 0, then ACK
      req = 4'b0001; wdata[7:0] = 8'hA5;
      push_grant(4'b0001, 8'hA5, 2'd0, 8'd1);
      step();
      req = 4'b0000;
      step();
      push_snap(4'b0000, 8'hA5, 2'd0, 1'b1, 8'd1);

      // reset back to ptr=0, then all four requesting continuously
      reset = 1'b1;
      step();
      reset = 1'b0;
      push_snap(4'b0000, 8'h00, 2'd0, 1'b0, 8'd0);
      wdata = {8'h13, 8'h12, 8'h11, 8'h10};
      req = 4'b1111;
      push_grant(4'b0001, 8'h10, 2'd0, 8'd1);
      push_grant(4'b0010, 8'h11, 2'd1, 8'd2);
      push_grant(4'b0100, 8'h12, 2'd2, 8'd3);
      push_grant(4'b1000, 8'h13, 2'd3, 8'd4);
      push_grant(4'b0001, 8'h10, 2'd0, 8'd5);
      step(9);
      req = 4'b0000;
      step();
      push_snap(4'b0000, 8'h10, 2'd0, 1'b1, 8'd5);

      // advance ptr to 2, then req=0011 must go 0 then 1
      req = 4'b0010;
      push_grant(4'b0010, 8'h11, 2'd1, 8'd6);
      step();
      req = 4'b0000;
      step();
      wdata[7:0] = 8'h20; wdata[15:8] = 8'h21;
      req = 4'b0011;
      push_grant(4'b0001, 8'h20, 2'd0, 8'd7);
      push_grant(4'b0010, 8'h21, 2'd1, 8'd8);
      step();
      req = 4'b0010;
      step(2);
      // requester 3 asserts only during ACK and drops before the IDLE edge
      req = 4'b1000; wdata[31:24] = 8'h77;
      step();
      req = 4'b0000;
      step();
      push_snap(4'b0000, 8'h21, 2'd1, 1'b1, 8'd8);

      // clr wins over a request in the same IDLE cycle
      wdata[23:16] = 8'h42;
      clr = 1'b1; req = 4'b0100;
      step();
      push_snap(4'b0000, 8'h00, 2'd1, 1'b0, 8'd8);
      clr = 1'b0;
      push_grant(4'b0100, 8'h42, 2'd2, 8'd9);
      step();
      // clr raised during ACK is ignored, then takes effect in IDLE
      req = 4'b0000; clr = 1'b1;
      step();
      push_snap(4'b0000, 8'h42, 2'd2, 1'b1, 8'd9);
      step();
      push_snap(4'b0000, 8'h00, 2'd2, 1'b0, 8'd9);
      clr = 1'b0;

      // ptr=3: scan wraps past 3 and 0 to requester 1, leaving ptr=2
      wdata[15:8] = 8'h55;
      req = 4'b0010;
      push_grant(4'b0010, 8'h55, 2'd1, 8'd10);
      step();
      // reset mid-ACK, then scanning restarts at requester 0
      req = 4'b0000; reset = 1'b1; clr = 1'b1;
      step();
      push_snap(4'b0000, 8'h00, 2'd0, 1'b0, 8'd0);
      reset = 1'b0; clr = 1'b0;
      req = 4'b0110;
      push_grant(4'b0010, 8'h55, 2'd1, 8'd1);
      push_grant(4'b0100, 8'h42, 2'd2, 8'd2);
      step();
      req = 4'b0100;
      step(2);
      req = 4'b0000;
      step(2);
      done = 1'b1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Monitor / scoreboard
   initial begin
      exp_t e;
      while (!done) begin
         @(negedge clk);
         if ((|gnt) === 1'b1) begin
            if (grant_q.size() == 0) begin
               chk("unexpected_grant", 32'(gnt), 32'h0);
            end else begin
               e = grant_q.pop_front();
               chk("grant_gnt",   32'(gnt),      32'(e.gnt));
               chk("grant_q",     32'(q),        32'(e.q));
               chk("grant_owner", 32'(owner),    32'(e.owner));
               chk("grant_valid", 32'(valid),    32'(e.valid));
               chk("grant_count", 32'(wr_count), 32'(e.cnt));
            end
         end
         if (snap_q.size() != 0) begin
            e = snap_q.pop_front();
            chk("snap_gnt",   32'(gnt),      32'(e.gnt));
            chk("snap_q",     32'(q),        32'(e.q));
            chk("snap_owner", 32'(owner),    32'(e.owner));
            chk("snap_valid", 32'(valid),    32'(e.valid));
            chk("snap_count", 32'(wr_count), 32'(e.cnt));
         end
      end
      chk("missing_grants", 32'(grant_q.size()), 32'h0);
      chk("missing_snaps",  32'(snap_q.size()),  32'h0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: bench did not complete, got running expected done");
      $fatal(1);
   end

endmodule
